pq_array: RTL
=============

PQ_ARRAY -- requirements
Module: pq_array

Interface
REQ-001 SHALL have parameter TW, default 16: priority (data) width; a lower value means a higher priority.
REQ-002 SHALL have parameter IW, default 4: task id width.
REQ-003 SHALL have parameter DEPTH, default 8: entry count, legal range 2..64.
REQ-004 SHALL have port clk_i, input, 1 bit: clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port push_valid_i, input, 1 bit: push request.
REQ-007 SHALL have port push_ready_o, output, 1 bit: push can be accepted this cycle.
REQ-008 SHALL have port push_data_i, input, TW bits: priority of the pushed entry.
REQ-009 SHALL have port push_id_i, input, IW bits: id of the pushed entry.
REQ-010 SHALL have port pop_i, input, 1 bit: remove the head entry.
REQ-011 SHALL have port peek_vld_o, output, 1 bit: head entry valid (queue not empty).
REQ-012 SHALL have port peek_data_o, output, TW bits: head priority.
REQ-013 SHALL have port peek_id_o, output, IW bits: head id.
REQ-014 SHALL have port drop_i, input, 1 bit: remove an entry by id.
REQ-015 SHALL have port drop_id_i, input, IW bits: id to remove.
REQ-016 SHALL have port drop_done_o, output, 1 bit: one-cycle pulse marking drop completion.
REQ-017 SHALL have port drop_hit_o, output, 1 bit: drop found a match; qualified by drop_done_o.
REQ-018 SHALL have port full_o, output, 1 bit: count equals DEPTH.
REQ-019 SHALL have port count_o, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-020 SHALL hold entries in slots 0..DEPTH-1, each with a valid bit; valid slots SHALL be contiguous from slot 0 and sorted ascending by data.
REQ-021 SHALL insert a new entry after all existing entries with equal data (FIFO tie-break).
REQ-022 SHALL drive peek_* combinationally from the slot 0 register only.
REQ-023 SHALL drive push_ready_o = !full_o | pop_i.
REQ-024 SHALL accept a push when push_valid_i & push_ready_o; the entry becomes visible in the sorted array on the next cycle.
REQ-025 SHALL accept a pop when pop_i & peek_vld_o: slots shift down by one at the next edge. A pop while empty SHALL be ignored with no state change.
REQ-026 SHALL perform push and pop together as remove-head-then-insert in one cycle, with count unchanged; legal when full.
REQ-027 SHALL accept a drop only when no push and no pop is accepted in the same cycle; otherwise drop_i SHALL be ignored and no drop_done_o pulse SHALL be produced.
REQ-028 SHALL remove only the lowest-index valid slot whose id matches an accepted drop, compacting the higher slots down by one.
REQ-029 SHALL pulse drop_done_o for one cycle on the cycle after an accepted drop, with drop_hit_o = 1 if a slot was removed and 0 otherwise.
REQ-030 SHALL update count_o as follows: +1 on push only; -1 on pop only or drop hit; unchanged otherwise.
REQ-031 SHALL set count_o and slot state, on a push while full without pop, to unchanged, because push_ready_o = 0.
REQ-032 SHALL complete every operation in a single cycle with no internal FSM stall; the block SHALL accept a new operation every cycle.

Reset
REQ-033 SHALL, on rst_ni low, asynchronously clear all valid bits, data and id.
REQ-034 SHALL, during and directly after reset, hold count_o = 0, full_o = 0, peek_vld_o = 0, peek_data_o = 0, peek_id_o = 0, drop_done_o = 0, drop_hit_o = 0 and push_ready_o = 1.
REQ-035 SHALL lose an operation in flight when reset asserts mid-operation, with no pending drop_done_o afterwards.

Configuration
REQ-036 SHALL, when PQ_DROP_EN is defined, include the drop logic per REQ-014..017 and REQ-027..029.
REQ-037 SHALL, when PQ_DROP_EN is undefined, keep the ports drop_i and drop_id_i but ignore them, tie drop_done_o and drop_hit_o to 0, and synthesise no id comparators.

Verification
REQ-038 SHALL cover: after reset, push (5,id1), (3,id2), (9,id3) -> peek = (3,id2), count = 3.
REQ-039 SHALL cover: push (4,id1) then (4,id2), then pop -> peek = (4,id2), proving FIFO tie-break.
REQ-040 SHALL cover: fill DEPTH=8 entries -> full_o = 1, push_ready_o = 0; push (1,idX) with pop_i=1 -> old head removed, head = (1,idX), count = 8.
REQ-041 SHALL cover: with entries ids 1..4, drop id3 -> next cycle drop_done_o = 1, drop_hit_o = 1, count = 3; drop id7 -> drop_done_o = 1, drop_hit_o = 0.
REQ-042 SHALL cover: drop_i together with pop_i -> pop performed, no drop_done_o; pop on empty -> count stays 0.
REQ-043 SHALL cover: rst_ni low mid-stream with count = 5 -> count_o = 0 and peek_vld_o = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/pq_array.sv
// Sorted priority-queue array: ascending by data, FIFO among equal data, head in slot 0.
// Define PQ_DROP_EN to build the remove-by-id (drop) logic; without it drop_* inputs are ignored.
module pq_array #(
    parameter int TW    = 16,
    parameter int IW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [TW-1:0]              push_data_i,
    input  logic [IW-1:0]              push_id_i,
    input  logic                       pop_i,
    output logic                       peek_vld_o,
    output logic [TW-1:0]              peek_data_o,
    output logic [IW-1:0]              peek_id_o,
    input  logic                       drop_i,
    input  logic [IW-1:0]              drop_id_i,
    output logic                       drop_done_o,
    output logic                       drop_hit_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic          vld_q  [DEPTH];
    logic [TW-1:0] data_q [DEPTH];
    logic [IW-1:0] id_q   [DEPTH];
    logic          vld_b  [DEPTH];
    logic [TW-1:0] data_b [DEPTH];
    logic [IW-1:0] id_b   [DEPTH];
    logic          vld_n  [DEPTH];
    logic [TW-1:0] data_n [DEPTH];
    logic [IW-1:0] id_n   [DEPTH];
    logic [CW-1:0] count_q;
    logic          drop_done_q, drop_hit_q;
    logic          push_acc, pop_acc, drop_acc, drop_rm, rm;
    int            drop_idx, rm_idx, ins_pos;

    // Push handshake: a push transfers on a cycle where push_valid_i and push_ready_o are both high;
    // ready only drops when full and no pop frees the head slot in the same cycle.
    assign full_o       = (count_q == CW'(DEPTH));
    assign push_ready_o = !full_o | pop_i;
    assign push_acc     = push_valid_i & push_ready_o;
    assign pop_acc      = pop_i & vld_q[0];

`ifdef PQ_DROP_EN
    logic drop_hit;
    assign drop_acc = drop_i & !push_acc & !pop_acc;

    // Scan from the top so the lowest matching slot wins.
    always_comb begin
        drop_hit = 1'b0;
        drop_idx = 0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (vld_q[i] && (id_q[i] == drop_id_i)) begin
                drop_hit = 1'b1;
                drop_idx = i;
            end
        end
    end
    assign drop_rm = drop_acc & drop_hit;
`else
    logic unused_drop;
    assign unused_drop = ^{drop_i, drop_id_i};
    assign drop_acc    = 1'b0;
    assign drop_rm     = 1'b0;
    assign drop_idx    = 0;
`endif

    // Removal stage: compact everything above the removed slot down by one.
    always_comb begin
        rm     = pop_acc | drop_rm;
        rm_idx = pop_acc ? 0 : drop_idx;
        for (int i = 0; i < DEPTH-1; i++) begin
            if (rm && (i >= rm_idx)) begin
                vld_b[i]  = vld_q[i+1];
                data_b[i] = data_q[i+1];
                id_b[i]   = id_q[i+1];
            end else begin
                vld_b[i]  = vld_q[i];
                data_b[i] = data_q[i];
                id_b[i]   = id_q[i];
            end
        end
        vld_b[DEPTH-1]  = rm ? 1'b0 : vld_q[DEPTH-1];
        data_b[DEPTH-1] = rm ? '0 : data_q[DEPTH-1];
        id_b[DEPTH-1]   = rm ? '0 : id_q[DEPTH-1];
    end

    // Insertion stage: new entry lands after every entry with data <= its own.
    always_comb begin
        ins_pos = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_b[i] && (data_b[i] <= push_data_i)) ins_pos = ins_pos + 1;
        end
        vld_n  = vld_b;
        data_n = data_b;
        id_n   = id_b;
        if (push_acc) begin
            if (ins_pos == 0) begin
                vld_n[0]  = 1'b1;
                data_n[0] = push_data_i;
                id_n[0]   = push_id_i;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (i == ins_pos) begin
                    vld_n[i]  = 1'b1;
                    data_n[i] = push_data_i;
                    id_n[i]   = push_id_i;
                end else if (i > ins_pos) begin
                    vld_n[i]  = vld_b[i-1];
                    data_n[i] = data_b[i-1];
                    id_n[i]   = id_b[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                data_q[i] <= '0;
                id_q[i]   <= '0;
            end
            count_q     <= '0;
            drop_done_q <= 1'b0;
            drop_hit_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= vld_n[i];
                data_q[i] <= data_n[i];
                id_q[i]   <= id_n[i];
            end
            case ({push_acc, rm})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            drop_done_q <= drop_acc;
            drop_hit_q  <= drop_rm;
        end
    end

    assign peek_vld_o  = vld_q[0];
    assign peek_data_o = data_q[0];
    assign peek_id_o   = id_q[0];
    assign count_o     = count_q;
    assign drop_done_o = drop_done_q;
    assign drop_hit_o  = drop_hit_q;
endmodule
